io_request_tracker: RTL and testbench

// Parametrised per-thread tracker for non-cacheable I/O loads/stores to memory-mapped registers.

---
 rtl/io_request_tracker.sv | 212 +++++++++++++++++++++
 tb/tb_io_request_tracker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_request_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : io_request_tracker                                               |
// | Brief   : Per-thread tracker for non-cacheable I/O loads/stores with a     |
// |           locked round-robin request grant toward the I/O interconnect.    |
// |           Optional response timeout enabled by `define IO_TIMEOUT_EN.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module io_request_tracker #(
    parameter int CORE_ID        = 0,
    parameter int NUM_THREADS    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int c_TIDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dd_io_write_en,
    input  logic                   dd_io_read_en,
    input  logic [c_TIDX_W-1:0]    dd_io_thread_idx,
    input  logic [DATA_WIDTH-1:0]  dd_io_addr,
    input  logic [DATA_WIDTH-1:0]  dd_io_write_value,
    output logic [DATA_WIDTH-1:0]  ior_read_value,
    output logic                   ior_rollback_en,
    output logic [NUM_THREADS-1:0] ior_pending,
    output logic [NUM_THREADS-1:0] ior_wake_bitmap,
    output logic [NUM_THREADS-1:0] ior_timeout_bitmap,
    input  logic                   ii_ready,
    input  logic                   ii_response_valid,
    input  logic [3:0]             ii_response_core,
    input  logic [c_TIDX_W-1:0]    ii_response_thread_idx,
    input  logic [DATA_WIDTH-1:0]  ii_response_read_value,
    output logic                   ior_request_valid,
    output logic                   ior_request_is_store,
    output logic [DATA_WIDTH-1:0]  ior_request_address,
    output logic [DATA_WIDTH-1:0]  ior_request_value,
    output logic [c_TIDX_W-1:0]    ior_request_thread_idx
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]            r_state    [NUM_THREADS];
    logic                  r_is_store [NUM_THREADS];
    logic [DATA_WIDTH-1:0] r_addr     [NUM_THREADS];
    logic [DATA_WIDTH-1:0] r_value    [NUM_THREADS];
    logic [c_TIDX_W-1:0]   r_ptr;
    logic [c_TIDX_W-1:0]   r_grant;
    logic                  r_locked;
    logic                  r_rollback;
    logic [DATA_WIDTH-1:0] r_read_value;

    logic                   w_access;
    logic                   w_resp_core_hit;
    logic                   w_req_valid;
    logic                   w_accept;
    logic [c_TIDX_W-1:0]    w_rr_sel;
    logic [c_TIDX_W-1:0]    w_sel;
    logic [NUM_THREADS-1:0] w_send_mask;
    logic [NUM_THREADS-1:0] w_dd_hit;
    logic [NUM_THREADS-1:0] w_accept_hit;
    logic [NUM_THREADS-1:0] w_resp_hit;
    logic [NUM_THREADS-1:0] w_timeout;
    logic [NUM_THREADS-1:0] w_timed_out;

    function automatic logic [c_TIDX_W-1:0] f_wrap(input int v);
        return c_TIDX_W'(v % NUM_THREADS);
    endfunction

    assign w_access        = dd_io_read_en | dd_io_write_en;
    assign w_resp_core_hit = ii_response_valid && (ii_response_core == 4'(CORE_ID));
    assign w_req_valid     = |w_send_mask;
    assign w_accept        = w_req_valid && ii_ready;

    // Scan from highest to lowest offset so the slot nearest the pointer wins.
    always_comb begin
        w_rr_sel = r_ptr;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (w_send_mask[f_wrap(int'(r_ptr) + i)]) begin
                w_rr_sel = f_wrap(int'(r_ptr) + i);
            end
        end
    end

    // Once a request is shown it is held on the same thread until accepted.
    assign w_sel = r_locked ? r_grant : w_rr_sel;

    generate
        for (genvar t = 0; t < NUM_THREADS; t++) begin : g_slot
            assign w_send_mask[t]  = (r_state[t] == c_SEND);
            assign w_dd_hit[t]     = w_access && (dd_io_thread_idx == c_TIDX_W'(t));
            assign w_accept_hit[t] = w_accept && (w_sel == c_TIDX_W'(t));
            assign w_resp_hit[t]   = w_resp_core_hit && (ii_response_thread_idx == c_TIDX_W'(t))
                                     && (r_state[t] == c_WAIT) && !w_timeout[t];
            assign ior_pending[t]  = (r_state[t] == c_WAIT)
                                     || ((r_state[t] == c_SEND) && (w_sel == c_TIDX_W'(t)));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_state[t]    <= c_IDLE;
                r_is_store[t] <= 1'b0;
                r_addr[t]     <= '0;
                r_value[t]    <= '0;
            end
            r_ptr        <= '0;
            r_grant      <= '0;
            r_locked     <= 1'b0;
            r_rollback   <= 1'b0;
            r_read_value <= '0;
        end else begin
            r_rollback   <= w_access && (r_state[dd_io_thread_idx] == c_IDLE);
            r_read_value <= r_value[dd_io_thread_idx];
            if (w_accept) begin
                r_locked <= 1'b0;
                r_ptr    <= f_wrap(int'(w_sel) + 1);
            end else if (w_req_valid) begin
                r_locked <= 1'b1;
                r_grant  <= w_sel;
            end
            for (int t = 0; t < NUM_THREADS; t++) begin
                case (r_state[t])
                    c_IDLE: if (w_dd_hit[t]) begin
                        r_state[t]    <= c_SEND;
                        r_is_store[t] <= dd_io_write_en;
                        r_addr[t]     <= dd_io_addr;
                        r_value[t]    <= dd_io_write_value;
                    end
                    c_SEND: if (w_accept_hit[t]) r_state[t] <= c_WAIT;
                    c_WAIT: if (w_timeout[t]) begin
                        r_state[t] <= c_DONE;
                        r_value[t] <= '1;
                    end else if (w_resp_hit[t]) begin
                        r_state[t] <= c_DONE;
                        if (!r_is_store[t]) r_value[t] <= ii_response_read_value;
                    end
                    c_DONE: if (w_dd_hit[t]) r_state[t] <= c_IDLE;
                    default: r_state[t] <= c_IDLE;
                endcase
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0]     r_wait_count [NUM_THREADS];
    logic [NUM_THREADS-1:0] r_timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) r_wait_count[t] <= '0;
            r_timed_out <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_accept_hit[t]) r_wait_count[t] <= '0;
                else if (r_state[t] == c_WAIT) r_wait_count[t] <= r_wait_count[t] + 1'b1;
                // The flag excuses a late response arriving after the forced completion.
                if (w_timeout[t]) r_timed_out[t] <= 1'b1;
                else if ((r_state[t] == c_DONE) && w_dd_hit[t]) r_timed_out[t] <= 1'b0;
            end
        end
    end

    generate
        for (genvar t = 0; t < NUM_THREADS; t++) begin : g_timeout
            assign w_timeout[t] = (r_state[t] == c_WAIT)
                                  && (r_wait_count[t] == c_CNT_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate
    assign w_timed_out = r_timed_out;
`else
    assign w_timeout   = '0;
    assign w_timed_out = '0;
`endif

    assign ior_read_value         = r_read_value;
    assign ior_rollback_en        = r_rollback;
    assign ior_wake_bitmap        = w_resp_hit | w_timeout;
    assign ior_timeout_bitmap     = w_timeout;
    assign ior_request_valid      = w_req_valid;
    assign ior_request_is_store   = r_is_store[w_sel];
    assign ior_request_address    = r_addr[w_sel];
    assign ior_request_value      = r_value[w_sel];
    assign ior_request_thread_idx = w_sel;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (NUM_THREADS >= 1 && TIMEOUT_CYCLES >= 2)
                else $error("io_request_tracker: bad parameters");
            assert (!(dd_io_read_en && dd_io_write_en))
                else $error("io_request_tracker: read and write enables both set");
            if (w_access) begin
                assert ((r_state[dd_io_thread_idx] != c_SEND) && (r_state[dd_io_thread_idx] != c_WAIT))
                    else $error("io_request_tracker: access to busy thread %0d", dd_io_thread_idx);
            end
            if (w_resp_core_hit && (r_state[ii_response_thread_idx] != c_WAIT)) begin
                assert (w_timed_out[ii_response_thread_idx])
                    else $warning("io_request_tracker: dropped response for idle thread %0d",
                                  ii_response_thread_idx);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_request_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_io_request_tracker                                            |
// | Brief   : Table, directed and randomized checks of io_request_tracker      |
// |           against a thread-level reference model.                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_io_request_tracker;

    localparam int NT   = 4;
    localparam int TW   = 2;
    localparam int DW   = 32;
    localparam int TO   = 8;
    localparam int CORE = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dd_wr, dd_rd;
    logic [TW-1:0] dd_tid;
    logic [DW-1:0] dd_addr, dd_wdata;
    logic [DW-1:0] rdval;
    logic          rollback;
    logic [NT-1:0] pending, wake, tmo;
    logic          ready, rv;
    logic [3:0]    rcore;
    logic [TW-1:0] rtid;
    logic [DW-1:0] rdata;
    logic          req_v, req_st;
    logic [DW-1:0] req_a, req_d;
    logic [TW-1:0] req_t;

    int checks = 0;
    int errors = 0;

    io_request_tracker #(
        .CORE_ID(CORE), .NUM_THREADS(NT), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .dd_io_write_en(dd_wr), .dd_io_read_en(dd_rd), .dd_io_thread_idx(dd_tid),
        .dd_io_addr(dd_addr), .dd_io_write_value(dd_wdata),
        .ior_read_value(rdval), .ior_rollback_en(rollback), .ior_pending(pending),
        .ior_wake_bitmap(wake), .ior_timeout_bitmap(tmo),
        .ii_ready(ready), .ii_response_valid(rv), .ii_response_core(rcore),
        .ii_response_thread_idx(rtid), .ii_response_read_value(rdata),
        .ior_request_valid(req_v), .ior_request_is_store(req_st),
        .ior_request_address(req_a), .ior_request_value(req_d),
        .ior_request_thread_idx(req_t)
    );

    always #5 clk = ~clk;

    // Reference model: what each thread is doing, in the specification's terms.
    typedef enum int {M_IDLE, M_SEND, M_WAIT, M_DONE} mph_t;
    mph_t          m_ph     [NT];
    logic          m_st     [NT];
    logic [DW-1:0] m_addr   [NT];
    logic [DW-1:0] m_val    [NT];
    int            m_waited [NT];
    int            m_ptr, m_grant;
    bit            m_locked;
    logic          m_rb;
    logic [DW-1:0] m_rd;
    int            acc_q [$];

    typedef struct {
        logic          rd;
        logic [DW-1:0] addr;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          e_valid;
        logic          e_rb;
        logic [NT-1:0] e_pend;
        logic [NT-1:0] e_wake;
        logic [DW-1:0] e_rd;
    } vec_t;
    vec_t tv [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        dd_wr = 0; dd_rd = 0; dd_tid = '0; dd_addr = '0; dd_wdata = '0;
        ready = 0; rv = 0; rcore = '0; rtid = '0; rdata = '0;
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_ph[t] = M_IDLE; m_st[t] = 0; m_addr[t] = '0; m_val[t] = '0; m_waited[t] = 0;
        end
        m_ptr = 0; m_grant = 0; m_locked = 0; m_rb = 0; m_rd = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    // Inputs are already applied; check outputs mid-cycle, then advance model and clock.
    task automatic cycle();
        bit            any_send;
        int            g, dt;
        logic [NT-1:0] e_pend, e_wake, e_to;
        #4;
        any_send = 0;
        for (int t = 0; t < NT; t++) if (m_ph[t] == M_SEND) any_send = 1;
        g = m_ptr;
        if (m_locked) g = m_grant;
        else begin
            for (int k = 0; k < NT; k++) begin
                if (m_ph[(m_ptr + k) % NT] == M_SEND) begin
                    g = (m_ptr + k) % NT;
                    break;
                end
            end
        end
        e_pend = '0; e_wake = '0; e_to = '0;
        for (int t = 0; t < NT; t++) if (m_ph[t] == M_WAIT) e_pend[t] = 1;
        if (any_send) e_pend[g] = 1;
`ifdef IO_TIMEOUT_EN
        for (int t = 0; t < NT; t++) if (m_ph[t] == M_WAIT && m_waited[t] + 1 == TO) e_to[t] = 1;
`endif
        if (rv && rcore == 4'(CORE) && m_ph[rtid] == M_WAIT && !e_to[rtid]) e_wake[rtid] = 1;
        e_wake |= e_to;

        chk("request_valid", req_v, any_send);
        if (any_send) begin
            chk("request_thread", req_t, g);
            chk("request_address", req_a, m_addr[g]);
            chk("request_value", req_d, m_val[g]);
            chk("request_is_store", req_st, m_st[g]);
            if (ready) acc_q.push_back(int'(req_t));
        end
        chk("pending", pending, e_pend);
        chk("wake", wake, e_wake);
        chk("timeout", tmo, e_to);
        chk("rollback", rollback, m_rb);
        chk("read_value", rdval, m_rd);

        dt   = int'(dd_tid);
        m_rb = (dd_rd || dd_wr) && m_ph[dt] == M_IDLE;
        m_rd = m_val[dt];
        for (int t = 0; t < NT; t++) begin
            if (m_ph[t] == M_WAIT) begin
                if (e_to[t]) begin
                    m_ph[t] = M_DONE; m_val[t] = '1;
                end else if (e_wake[t]) begin
                    m_ph[t] = M_DONE;
                    if (!m_st[t]) m_val[t] = rdata;
                end else m_waited[t]++;
            end
        end
        if (any_send && ready) begin
            m_ph[g] = M_WAIT; m_waited[g] = 0; m_locked = 0; m_ptr = (g + 1) % NT;
        end else if (any_send) begin
            m_locked = 1; m_grant = g;
        end
        if (dd_rd || dd_wr) begin
            if (m_ph[dt] == M_IDLE) begin
                m_ph[dt] = M_SEND; m_st[dt] = dd_wr; m_addr[dt] = dd_addr; m_val[dt] = dd_wdata;
            end else if (m_ph[dt] == M_DONE) m_ph[dt] = M_IDLE;
        end
        @(posedge clk); #1;
    endtask

    task automatic access(input bit wr, input int t, input logic [DW-1:0] a, input logic [DW-1:0] d);
        dd_wr = wr; dd_rd = !wr; dd_tid = TW'(t); dd_addr = a; dd_wdata = d;
    endtask

    initial begin
        int t, t2;
        idle_inputs();
        model_reset();

        // Single load on thread 1 with a response five cycles after acceptance.
        tv[0] = '{1, 32'hFFFF0004, 0, 0,      0, 0, 4'b0000, 4'b0000, 0};
        tv[1] = '{0, 0,            0, 0,      1, 1, 4'b0010, 4'b0000, 0};
        tv[2] = '{0, 0,            0, 0,      0, 0, 4'b0010, 4'b0000, 0};
        tv[3] = '{0, 0,            0, 0,      0, 0, 4'b0010, 4'b0000, 0};
        tv[4] = '{0, 0,            0, 0,      0, 0, 4'b0010, 4'b0000, 0};
        tv[5] = '{0, 0,            0, 0,      0, 0, 4'b0010, 4'b0000, 0};
        tv[6] = '{0, 0,            1, 'h1234, 0, 0, 4'b0010, 4'b0010, 0};
        tv[7] = '{1, 32'hFFFF0004, 0, 0,      0, 0, 4'b0000, 4'b0000, 0};
        tv[8] = '{0, 0,            0, 0,      0, 0, 4'b0000, 4'b0000, 'h1234};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            dd_rd = tv[i].rd; dd_tid = 1; dd_addr = tv[i].addr; ready = 1;
            rv = tv[i].rv; rcore = 4'(CORE); rtid = 1; rdata = tv[i].rdata;
            #4;
            chk($sformatf("t1_valid[%0d]", i), req_v, tv[i].e_valid);
            chk($sformatf("t1_rollback[%0d]", i), rollback, tv[i].e_rb);
            chk($sformatf("t1_pending[%0d]", i), pending, tv[i].e_pend);
            chk($sformatf("t1_wake[%0d]", i), wake, tv[i].e_wake);
            chk($sformatf("t1_read_value[%0d]", i), rdval, tv[i].e_rd);
            @(posedge clk); #1;
        end

        // Three stores held off by the interconnect, then accepted in order 0,2,3.
        do_reset();
        access(1, 0, 'h100, 'hA0); cycle();
        idle_inputs(); access(1, 2, 'h200, 'hA2); cycle();
        idle_inputs(); access(1, 3, 'h300, 'hA3); cycle();
        idle_inputs(); #2;
        chk("t2_held_thread", req_t, 0);
        chk("t2_held_address", req_a, 'h100);
        cycle();
        acc_q.delete();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); ready = 1; cycle();
        end
        chk("t2_accept_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("t2_accept_0", acc_q[0], 0);
            chk("t2_accept_1", acc_q[1], 2);
            chk("t2_accept_2", acc_q[2], 3);
        end

        // New load on thread 0 while thread 2 waits, then a foreign-core response.
        do_reset();
        access(1, 2, 'h20, 'h22); ready = 1; cycle();
        idle_inputs(); ready = 1; cycle();
        idle_inputs(); access(0, 0, 'h40, 0); ready = 1; cycle();
        idle_inputs(); ready = 1; #2;
        chk("t3_pending", pending, 4'b0101);
        chk("t3_thread", req_t, 0);
        cycle();
        idle_inputs(); rv = 1; rcore = 4'd3; rtid = 2; rdata = 'hBAD; #2;
        chk("t4_wake", wake, 4'b0000);
        cycle();
        idle_inputs(); #2;
        chk("t4_pending", pending, 4'b0101);
        cycle();

`ifdef IO_TIMEOUT_EN
        // Load that never gets a response is forced complete on its 8th WAIT cycle.
        do_reset();
        access(0, 0, 'h80, 0); ready = 1; cycle();
        idle_inputs(); ready = 1; cycle();
        for (int i = 0; i < TO - 1; i++) begin
            idle_inputs(); cycle();
        end
        idle_inputs(); #2;
        chk("t5_timeout", tmo, 4'b0001);
        chk("t5_wake", wake, 4'b0001);
        cycle();
        idle_inputs(); rv = 1; rcore = 4'(CORE); rtid = 0; rdata = 'h55; #2;
        chk("t5_late_wake", wake, 4'b0000);
        cycle();
        idle_inputs(); access(0, 0, 'h80, 0); cycle();
        idle_inputs(); #2;
        chk("t5_read_value", rdval, 32'hFFFFFFFF);
        chk("t5_rollback", rollback, 0);
        cycle();
`endif

        // Asynchronous reset with thread 1 waiting and thread 3 just issued.
        do_reset();
        access(0, 1, 'h10, 0); ready = 1; cycle();
        idle_inputs(); ready = 1; cycle();
        idle_inputs(); access(1, 3, 'h30, 'h33); cycle();
        idle_inputs(); #2;
        chk("t6_pre_pending", pending, 4'b1010);
        reset = 1; #1;
        chk("t6_rst_pending", pending, 4'b0000);
        chk("t6_rst_valid", req_v, 0);
        chk("t6_rst_rollback", rollback, 0);
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        rv = 1; rcore = 4'(CORE); rtid = 1; rdata = 'h77; #2;
        chk("t6_late_wake", wake, 4'b0000);
        cycle();

        // Randomized legal traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            t = $urandom_range(0, NT - 1);
            if ($urandom_range(0, 2) != 0 && (m_ph[t] == M_IDLE || m_ph[t] == M_DONE))
                access($urandom_range(0, 1) == 1, t, $urandom, $urandom);
            ready = ($urandom_range(0, 1) == 1);
            t2 = $urandom_range(0, NT - 1);
            if (m_ph[t2] == M_WAIT && $urandom_range(0, 3) == 0) begin
                rv = 1; rtid = TW'(t2); rdata = $urandom;
                rcore = ($urandom_range(0, 4) == 0) ? 4'd3 : 4'(CORE);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
